mesh_term_src: RTL and testbench
================================

# mesh_term_src

Terminal-side packet source feeding one external port of `mesh_gnrtr`. It accepts destination/mode/payload requests from a local producer and validates the destination against the mesh terminal map. It stamps the mesh header, buffers packets in a FIFO, and presents them to the router through the `pndng_i_in` / `data_out_i_in` / `pop` handshake the mesh expects on each terminal input.

## Interface
Parameters:
- `ROWS`, default 4: mesh rows.
- `COLUMS`, default 4: mesh columns.
- `pckg_sz`, default 40: packet width; must be ≥ 24.
- `fifo_depth`, default 4: buffered packets; power of two, ≥ 2.
- `SELF_ROW`, default 0: this terminal's row coordinate.
- `SELF_COL`, default 1: this terminal's column coordinate.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `push`  in  1  producer request, qualified on a clock edge.
- `push_row`  in  4  destination row.
- `push_col`  in  4  destination column.
- `push_mode`  in  1  routing mode bit (0: row first, 1: column first).
- `push_payload`  in  pckg_sz-17  payload.
- `push_rdy`  out  1  high when not full.
- `reject`  out  1  one-cycle pulse when a push is dropped.
- `pndng_i_in`  out  1  head packet available to the mesh.
- `data_out_i_in`  out  pckg_sz  head packet.
- `pop`  in  1  mesh consumes the head.
- `count`  out  $clog2(fifo_depth)+1  occupancy.
- `sent_cnt`  out  16  packets popped; saturates at 0xFFFF.
- `drop_cnt`  out  16  pushes rejected; saturates at 0xFFFF.

## Operation
- Packet format:
  - `[pckg_sz-1:pckg_sz-8]` Nxt_jump, stamped as 0.
  - `[pckg_sz-9:pckg_sz-12]` row.
  - `[pckg_sz-13:pckg_sz-16]` column.
  - `[pckg_sz-17]` mode.
  - `[pckg_sz-18:0]` payload.
- A destination is legal iff it is a terminal position and not (`SELF_ROW`, `SELF_COL`). Terminal positions are:
  - row ∈ {0, ROWS+1} with col 1..COLUMS; or
  - col ∈ {0, COLUMS+1} with row 1..ROWS.
- Push handling on an edge with `push`=1:
  - Legal destination and (not full, or `pop` accepted in the same cycle): packet written at the write pointer.
  - Otherwise: packet dropped, `reject` pulses on the next cycle, `drop_cnt` +1.
- `pop` is honoured only when `pndng_i_in`=1. A pop while empty is ignored and changes no counter.
- Read and write pointers are `$clog2(fifo_depth)` bits and wrap modulo `fifo_depth`. `count` tracks occupancy in the range 0..fifo_depth.
- Derived outputs:
  - `pndng_i_in` = (count ≠ 0).
  - `push_rdy` = (count ≠ fifo_depth).
  - `data_out_i_in` = entry at the read pointer when non-empty, else all zeros.
- Simultaneous push and pop:
  - Full: both take effect; `count` unchanged; the new packet lands in the slot freed by the pop.
  - Empty: pop ignored; push accepted.
- Counters saturate and never wrap.

## Timing
- Reset values:
  - `push_rdy`=1; `reject`=0; `pndng_i_in`=0; `data_out_i_in`=0.
  - `count`=0; `sent_cnt`=0; `drop_cnt`=0.
  - Pointers = 0. Storage contents are don't-care.
- Push latency: a push accepted at edge k makes `pndng_i_in`=1 and the packet visible on `data_out_i_in` after edge k (registered status, one cycle).
- Pop: the pop sampled at edge k advances the head. The next packet, or zeros and `pndng_i_in`=0, appears after edge k.
- `data_out_i_in` stays stable while `pndng_i_in`=1 and no pop is sampled.
- `reject` is registered: high for exactly one cycle after the offending edge.
- Reset asserted mid-operation: at that edge all buffered packets are discarded and all outputs return to reset values. Any `push` or `pop` on that edge is ignored.

## Structure
- Shared package `mesh_pkg` holds:
  - the header field offsets and widths (`NXT_JMP_W`=8, `ID_W`=4, mode bit position);
  - `function is_terminal(row, col, ROWS, COLUMS)`;
  - the packed struct `mesh_hdr_t`.
- Sub-module `mesh_sync_fifo`: a generic synchronous FIFO with full/empty/count. `mesh_term_src` wraps it with the validation, header-stamping and counter logic.

## Test plan
- Reset, then push (row 0, col 3, mode 0, payload 0x5A) with `SELF_ROW`=0, `SELF_COL`=1 → next cycle `pndng_i_in`=1 and `data_out_i_in` = {8'h00, 4'h0, 4'h3, 1'b0, payload 0x5A}; pop → `pndng_i_in`=0, `sent_cnt`=1.
- Push 4 legal packets with no pop (fifo_depth=4) → `count`=4, `push_rdy`=0; a 5th push → `reject` pulse, `drop_cnt`=1; the 4 packets pop out in order.
- Full FIFO, push and pop on the same edge → `count` stays 4, `reject` stays 0; popped order is A,B,C,D then the new packet.
- Push to self (0,1), to (0,0), to (2,2) and to (5,6) → each rejected, `drop_cnt`=4, `count`=0.
- Pop while empty → no change to `count` or `sent_cnt`; push and pop together while empty → `count`=1.
- Fill with 3 packets, assert `reset` for one cycle → `count`=0, `pndng_i_in`=0, counters 0; a subsequent push is presented correctly.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared mesh definitions: header field widths, header layout and terminal-map test.
package mesh_pkg;

  localparam int NXT_JMP_W = 8;
  localparam int ID_W      = 4;
  // Mode bit sits this many bits below the packet MSB; payload fills everything beneath it.
  localparam int MODE_OFS  = NXT_JMP_W + 2 * ID_W;
  localparam int HDR_W     = MODE_OFS + 1;

  typedef struct packed {
    logic [NXT_JMP_W-1:0] nxt_jump;
    logic [ID_W-1:0]      row;
    logic [ID_W-1:0]      col;
    logic                 mode;
  } mesh_hdr_t;

  // Terminals ring the mesh: top/bottom edge rows and left/right edge columns, corners excluded.
  function automatic logic is_terminal(input logic [ID_W-1:0] row, input logic [ID_W-1:0] col,
                                       input int rows, input int cols);
    int r;
    int c;
    r = int'(row);
    c = int'(col);
    return (((r == 0) || (r == rows + 1)) && (c >= 1) && (c <= cols)) ||
           (((c == 0) || (c == cols + 1)) && (r >= 1) && (r <= rows));
  endfunction

endpackage

// File: rtl/mesh_sync_fifo.sv
// Generic synchronous FIFO; read data is the head entry, zero when empty.
module mesh_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_ok, wr_ok;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A write into a full FIFO is allowed only when the head leaves on the same edge.
  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst && wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/mesh_term_src.sv
// Terminal packet source: validates destination, stamps the mesh header and queues
// packets for the router's pndng/data/pop terminal handshake.
module mesh_term_src
  import mesh_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int SELF_ROW   = 0,
  parameter int SELF_COL   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [3:0]                    push_row,
  input  logic [3:0]                    push_col,
  input  logic                          push_mode,
  input  logic [pckg_sz-18:0]           push_payload,
  output logic                          push_rdy,
  output logic                          reject,
  output logic                          pndng_i_in,
  output logic [pckg_sz-1:0]            data_out_i_in,
  input  logic                          pop,
  output logic [$clog2(fifo_depth):0]   count,
  output logic [15:0]                   sent_cnt,
  output logic [15:0]                   drop_cnt
);

  localparam int MODE_BIT = pckg_sz - 1 - MODE_OFS;

  mesh_hdr_t          hdr;
  logic [pckg_sz-1:0] pkt;
  logic               legal, full, empty, pop_ok, push_ok;
  logic               reject_q, reject_d;
  logic [15:0]        sent_cnt_q, sent_cnt_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  assign legal = is_terminal(push_row, push_col, ROWS, COLUMS) &&
                 !((push_row == ID_W'(SELF_ROW)) && (push_col == ID_W'(SELF_COL)));

  always_comb begin
    hdr          = '0;
    hdr.nxt_jump = '0;
    hdr.row      = push_row;
    hdr.col      = push_col;
    hdr.mode     = push_mode;
  end

  assign pkt = {hdr, push_payload[MODE_BIT-1:0]};

  // Mirrors the FIFO's own accept rule so drops are counted on exactly the pushes it refuses.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && legal && (!full || pop_ok);

  mesh_sync_fifo #(
    .W     (pckg_sz),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .srst      (reset),
    .wr_en_i   (push && legal),
    .wr_data_i (pkt),
    .rd_en_i   (pop),
    .rd_data_o (data_out_i_in),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count)
  );

  always_comb begin
    reject_d   = push && !push_ok;
    sent_cnt_d = sent_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pop_ok && (sent_cnt_q != 16'hFFFF)) sent_cnt_d = sent_cnt_q + 16'd1;
    if (reject_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reject_q   <= 1'b0;
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      reject_q   <= reject_d;
      sent_cnt_q <= sent_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pndng_i_in = !empty;
  assign push_rdy   = !full;
  assign reject     = reject_q;
  assign sent_cnt   = sent_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_mesh_term_src.sv
// Directed bench for mesh_term_src: queue-based model checked every cycle plus literal pins.
module tb_mesh_term_src;

  localparam int PW    = 40;
  localparam int DEPTH = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int SR    = 0;
  localparam int SC    = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              push = 1'b0;
  logic [3:0]        push_row = '0;
  logic [3:0]        push_col = '0;
  logic              push_mode = 1'b0;
  logic [PW-18:0]    push_payload = '0;
  logic              pop = 1'b0;
  logic              push_rdy, reject, pndng_i_in;
  logic [PW-1:0]     data_out_i_in;
  logic [2:0]        count;
  logic [15:0]       sent_cnt, drop_cnt;

  mesh_term_src #(
    .ROWS(ROWS), .COLUMS(COLS), .pckg_sz(PW), .fifo_depth(DEPTH),
    .SELF_ROW(SR), .SELF_COL(SC)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .push_row(push_row), .push_col(push_col),
    .push_mode(push_mode), .push_payload(push_payload), .push_rdy(push_rdy),
    .reject(reject), .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in),
    .pop(pop), .count(count), .sent_cnt(sent_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: set of terminal coordinates, a packet queue and counters.
  bit            term_map [16][16];
  logic [PW-1:0] mq[$];
  int            m_sent = 0;
  int            m_drop = 0;
  bit            m_reject = 0;
  bit            live = 0;

  initial begin
    for (int c = 1; c <= COLS; c++) begin
      term_map[0][c] = 1;
      term_map[ROWS+1][c] = 1;
    end
    for (int r = 1; r <= ROWS; r++) begin
      term_map[r][0] = 1;
      term_map[r][COLS+1] = 1;
    end
  end

  always @(posedge clk) begin : model
    bit pop_ok, push_ok, lg;
    if (reset) begin
      mq.delete();
      m_sent = 0;
      m_drop = 0;
      m_reject = 0;
      live = 1;
    end else begin
      lg      = term_map[push_row][push_col] && !(push_row == SR && push_col == SC);
      pop_ok  = pop && (mq.size() > 0);
      push_ok = push && lg && ((mq.size() < DEPTH) || pop_ok);
      m_reject = push && !push_ok;
      if (pop_ok) begin
        void'(mq.pop_front());
        if (m_sent < 65535) m_sent++;
      end
      if (push_ok) mq.push_back({8'h00, push_row, push_col, push_mode, push_payload});
      if (m_reject && m_drop < 65535) m_drop++;
    end
  end

  always @(negedge clk) begin
    logic [PW-1:0] exp_data;
    if (live) begin
      exp_data = (mq.size() > 0) ? mq[0] : '0;
      chk("count",    64'(count),         64'(mq.size()));
      chk("pndng",    64'(pndng_i_in),    64'(mq.size() != 0));
      chk("push_rdy", 64'(push_rdy),      64'(mq.size() != DEPTH));
      chk("data",     64'(data_out_i_in), 64'(exp_data));
      chk("reject",   64'(reject),        64'(m_reject));
      chk("sent_cnt", 64'(sent_cnt),      64'(m_sent));
      chk("drop_cnt", 64'(drop_cnt),      64'(m_drop));
    end
  end

  task automatic cyc(input bit p, input int r, input int c, input bit m, input int pl,
                     input bit pp, input bit rs = 1'b0);
    push = p; push_row = 4'(r); push_col = 4'(c); push_mode = m;
    push_payload = (PW-17)'(pl); pop = pp; reset = rs;
    @(posedge clk); #1;
    $display("cyc rst=%0b push=%0b dst=(%0d,%0d) pl=0x%0h pop=%0b -> count=%0d pndng=%0b reject=%0b sent=%0d drop=%0d",
             rs, p, r, c, pl, pp, count, pndng_i_in, reject, sent_cnt, drop_cnt);
    push = 1'b0; pop = 1'b0; reset = 1'b0;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pndng", 64'(pndng_i_in), 64'd0);
    chk("rst_data",  64'(data_out_i_in), 64'd0);
    chk("rst_rdy",   64'(push_rdy), 64'd1);

    // Single packet in and out.
    cyc(1, 0, 3, 0, 'h5A, 0);
    chk("first_pndng", 64'(pndng_i_in), 64'd1);
    chk("first_data",  64'(data_out_i_in), 64'h00_0300_005A);
    cyc(0, 0, 0, 0, 0, 1);
    chk("first_pop_pndng", 64'(pndng_i_in), 64'd0);
    chk("first_pop_sent",  64'(sent_cnt), 64'd1);

    // Fill, overflow, drain in order.
    cyc(1, 0, 2, 0, 1, 0);
    cyc(1, 0, 3, 1, 2, 0);
    cyc(1, 0, 4, 0, 3, 0);
    cyc(1, 1, 0, 1, 4, 0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_rdy",   64'(push_rdy), 64'd0);
    cyc(1, 2, 0, 0, 5, 0);
    chk("ovf_reject", 64'(reject), 64'd1);
    chk("ovf_drop",   64'(drop_cnt), 64'd1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ovf_reject_clr", 64'(reject), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 64'(data_out_i_in[22:0]), 64'(i));
      cyc(0, 0, 0, 0, 0, 1);
    end

    // Full with simultaneous push and pop.
    cyc(1, 3, 5, 0, 'h11, 0);
    cyc(1, 4, 0, 0, 'h12, 0);
    cyc(1, 5, 1, 1, 'h13, 0);
    cyc(1, 5, 4, 0, 'h14, 0);
    cyc(1, 5, 2, 0, 'h15, 1);
    chk("pp_count",  64'(count), 64'd4);
    chk("pp_reject", 64'(reject), 64'd0);
    for (int i = 'h12; i <= 'h15; i++) begin
      chk("pp_order", 64'(data_out_i_in[22:0]), 64'(i));
      cyc(0, 0, 0, 0, 0, 1);
    end

    // Reset (push on the reset edge is ignored), then illegal destinations.
    cyc(1, 0, 2, 0, 'h77, 1, 1);
    cyc(1, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 2, 0);
    cyc(1, 2, 2, 0, 3, 0);
    cyc(1, 5, 6, 0, 4, 0);
    chk("illegal_drop",  64'(drop_cnt), 64'd4);
    chk("illegal_count", 64'(count), 64'd0);

    // Empty-FIFO pop behaviour.
    cyc(0, 0, 0, 0, 0, 1);
    chk("empty_pop_count", 64'(count), 64'd0);
    chk("empty_pop_sent",  64'(sent_cnt), 64'd0);
    cyc(1, 1, 5, 0, 'h21, 1);
    chk("empty_pp_count", 64'(count), 64'd1);

    // Mid-operation reset with pop asserted, then a fresh push.
    cyc(1, 2, 5, 0, 'h22, 0);
    cyc(1, 3, 0, 1, 'h23, 0);
    chk("pre_rst_count", 64'(count), 64'd3);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_pndng", 64'(pndng_i_in), 64'd0);
    chk("mid_rst_sent",  64'(sent_cnt), 64'd0);
    chk("mid_rst_drop",  64'(drop_cnt), 64'd0);
    cyc(1, 4, 5, 1, 'h1234, 0);
    chk("post_rst_data", 64'(data_out_i_in), 64'h00_4580_1234);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
